// File: rtl/fpu_issue_scoreboard_pkg.sv
// Shared types and constants for the FPU issue scoreboard.
package fpu_issue_scoreboard_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic WP_PIPE = 1'b0;
  localparam logic WP_FPU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    WB_PEND = 2'd2
  } sb_state_t;

endpackage

// File: rtl/fpu_issue_scoreboard_hazard_cmp.sv
// Address + register-file comparator against the pending FPU destination.
// Integer x0 as the pending destination never matches; float f0 does.
module fpu_hazard_cmp
  import fpu_issue_scoreboard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] addr,
  input  logic              addr_f,
  input  logic [REG_AW-1:0] pend_rd,
  input  logic              pend_f,
  output logic              match
);

  assign match = (addr == pend_rd) && (addr_f == pend_f) &&
                 (pend_f || (pend_rd != '0));

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// Single-entry FPU scoreboard: decode hazard stalls and arbitration of the
// shared register-file write port between pipeline writeback and FPU results.
module fpu_issue_scoreboard
  import fpu_issue_scoreboard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int WB_PEND_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_fpu_op,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_f,
  input  logic              id_rs2_f,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_f,
  input  logic              id_wr,
  input  logic              wb_we,
  input  logic              wb_wef,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic              fpu_done,
  output logic              stall,
  output logic              fpu_start,
  output logic              fpu_ack,
  output logic              wp_sel,
  output logic              wp_we,
  output logic              wp_wef,
  output logic [REG_AW-1:0] wp_wa,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(WB_PEND_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WB_PEND_MAX);

  sb_state_t         state, state_nxt;
  logic [REG_AW-1:0] pend_rd;
  logic              pend_f;
  logic [CNT_W-1:0]  pend_cnt, pend_cnt_nxt;
  logic              match_rs1, match_rs2, match_rd;
  logic              hazard, stall_int, launch, commit, err_set, wb_busy;

  fpu_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
    .addr(id_rs1), .addr_f(id_rs1_f), .pend_rd(pend_rd), .pend_f(pend_f), .match(match_rs1)
  );
  fpu_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
    .addr(id_rs2), .addr_f(id_rs2_f), .pend_rd(pend_rd), .pend_f(pend_f), .match(match_rs2)
  );
  fpu_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rd (
    .addr(id_rd), .addr_f(id_rd_f), .pend_rd(pend_rd), .pend_f(pend_f), .match(match_rd)
  );

  assign wb_busy   = wb_we | wb_wef;
  assign hazard    = match_rs1 | match_rs2 | (id_wr & match_rd) | id_fpu_op |
                     (state == WB_PEND);
  assign stall_int = id_valid & (state != IDLE) & hazard;
  assign launch    = id_valid & id_fpu_op & ~stall_int & (state == IDLE);

  always_comb begin
    state_nxt    = state;
    pend_cnt_nxt = pend_cnt;
    commit       = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_nxt = BUSY;
        if (fpu_done) err_set = 1'b1;
      end
      BUSY: begin
        if (fpu_done) begin
          if (wb_busy) begin
            state_nxt    = WB_PEND;
            pend_cnt_nxt = '0;
          end else begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WB_PEND: begin
        if (!wb_busy) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else begin
          pend_cnt_nxt = (pend_cnt == CNT_MAX) ? pend_cnt : pend_cnt + 1'b1;
          if (pend_cnt_nxt == CNT_MAX) err_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_rd   <= '0;
      pend_f    <= 1'b0;
      pend_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_cnt <= pend_cnt_nxt;
      if (err_set) proto_err <= 1'b1;
      // A non-writing op parks on integer x0 so it can never match.
      if (launch) begin
        pend_rd <= id_wr ? id_rd : '0;
        pend_f  <= id_wr ? id_rd_f : 1'b0;
      end
    end
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    stall     = stall_int & ~rst;
    fpu_start = launch & ~rst;
    fpu_ack   = commit & ~rst;
    wp_sel    = WP_PIPE;
    wp_we     = wb_we & ~rst;
    wp_wef    = wb_wef & ~rst;
    wp_wa     = rst ? '0 : wb_wa;
    if (commit && !rst) begin
      wp_sel = WP_FPU;
      wp_we  = ~pend_f & (pend_rd != '0);
      wp_wef = pend_f;
      wp_wa  = pend_rd;
    end
  end

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Directed self-checking bench for fpu_issue_scoreboard.
module tb_fpu_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_fpu_op, id_rs1_f, id_rs2_f, id_rd_f, id_wr;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_wa, wp_wa;
  logic       wb_we, wb_wef, fpu_done;
  logic       stall, fpu_start, fpu_ack, wp_sel, wp_we, wp_wef, proto_err;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fpu_issue_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_fpu_op(id_fpu_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_f(id_rs1_f), .id_rs2_f(id_rs2_f),
    .id_rd(id_rd), .id_rd_f(id_rd_f), .id_wr(id_wr),
    .wb_we(wb_we), .wb_wef(wb_wef), .wb_wa(wb_wa), .fpu_done(fpu_done),
    .stall(stall), .fpu_start(fpu_start), .fpu_ack(fpu_ack), .wp_sel(wp_sel),
    .wp_we(wp_we), .wp_wef(wp_wef), .wp_wa(wp_wa), .proto_err(proto_err)
  );

  task automatic clear_inputs();
    id_valid = 0; id_fpu_op = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_f = 0; id_rs2_f = 0;
    id_rd = 0; id_rd_f = 0; id_wr = 0; wb_we = 0; wb_wef = 0; wb_wa = 0; fpu_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; #3; rst = 0;
    tick();
  endtask

  // Drive an FPU op with an unrelated source set (x1, x2) into an idle scoreboard.
  task automatic issue_op(input logic [4:0] rd, input logic rd_f, input logic wr);
    clear_inputs();
    id_valid = 1; id_fpu_op = 1; id_rs1 = 1; id_rs2 = 2; id_rd = rd; id_rd_f = rd_f; id_wr = wr;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    id_valid = 1; id_fpu_op = 1; wb_we = 1; wb_wa = 5'd9; fpu_done = 1;
    settle();
    tests++; if ({stall, fpu_start, fpu_ack, wp_sel, wp_we, wp_wef, wp_wa, proto_err} !== 12'h000) begin
      failed++; $display("FAIL reset_outputs: got %0h expected 0",
        {stall, fpu_start, fpu_ack, wp_sel, wp_we, wp_wef, wp_wa, proto_err});
    end
    tick();
    rst = 0;
    clear_inputs();
    tick();
    // Launch rd=f3, then reset while BUSY with a dependent reader in decode.
    issue_op(5'd3, 1'b1, 1'b1);
    tick();
    clear_inputs();
    id_valid = 1; id_rs1 = 3; id_rs1_f = 1;
    settle();
    tests++; if (stall !== 1'b1) begin failed++; $display("FAIL reset_pre_stall: got %0b expected 1", stall); end
    rst = 1;
    settle();
    tests++; if ({stall, fpu_start, fpu_ack, wp_sel, wp_we, wp_wef, wp_wa} !== 11'h000) begin
      failed++; $display("FAIL reset_busy_outputs: got %0h expected 0",
        {stall, fpu_start, fpu_ack, wp_sel, wp_we, wp_wef, wp_wa});
    end
    rst = 0;
    settle();
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL reset_idle_nostall: got %0b expected 0", stall); end
    issue_op(5'd3, 1'b1, 1'b1);
    settle();
    tests++; if ({stall, fpu_start} !== 2'b01) begin
      failed++; $display("FAIL reset_relaunch: got stall,start=%0b expected 01", {stall, fpu_start});
    end
    tick();
    clear_inputs(); fpu_done = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_raw();
    issue_op(5'd5, 1'b1, 1'b1);
    settle();
    tests++; if ({stall, fpu_start} !== 2'b01) begin
      failed++; $display("FAIL raw_launch: got stall,start=%0b expected 01", {stall, fpu_start});
    end
    tick();
    clear_inputs();
    id_valid = 1; id_rs1 = 5; id_rs1_f = 1; id_rs2 = 6; id_rs2_f = 1; id_rd = 7; id_rd_f = 1; id_wr = 1;
    settle();
    tests++; if ({stall, fpu_start} !== 2'b10) begin
      failed++; $display("FAIL raw_busy1: got stall,start=%0b expected 10", {stall, fpu_start});
    end
    tick();
    settle();
    tests++; if (stall !== 1'b1) begin failed++; $display("FAIL raw_busy2: got %0b expected 1", stall); end
    fpu_done = 1;
    settle();
    tests++; if ({stall, fpu_ack, wp_sel, wp_we, wp_wef, wp_wa} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5}) begin
      failed++; $display("FAIL raw_commit: got %0h expected %0h",
        {stall, fpu_ack, wp_sel, wp_we, wp_wef, wp_wa}, {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5});
    end
    tick();
    fpu_done = 0;
    settle();
    tests++; if ({stall, fpu_ack, wp_sel} !== 3'b000) begin
      failed++; $display("FAIL raw_release: got %0b expected 000", {stall, fpu_ack, wp_sel});
    end
    clear_inputs();
  endtask

  task automatic test_waw_and_file_mask();
    issue_op(5'd5, 1'b1, 1'b1);
    tick();
    clear_inputs();
    id_valid = 1; id_rs1 = 5; id_rs1_f = 0; id_rs2 = 5; id_rs2_f = 0; id_rd = 5; id_rd_f = 0; id_wr = 1;
    settle();
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL int_x5_vs_f5: got %0b expected 0", stall); end
    id_rs1 = 9; id_rs2 = 10; id_rd = 5; id_rd_f = 1; id_wr = 1;
    settle();
    tests++; if (stall !== 1'b1) begin failed++; $display("FAIL waw_f5: got %0b expected 1", stall); end
    id_wr = 0;
    settle();
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL waw_nowrite: got %0b expected 0", stall); end
    clear_inputs(); fpu_done = 1;
    tick();
    clear_inputs();
    // Non-writing op parks on integer x0.
    issue_op(5'd12, 1'b0, 1'b0);
    tick();
    clear_inputs();
    id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_wr = 1;
    settle();
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL x0_reader: got %0b expected 0", stall); end
    clear_inputs(); fpu_done = 1;
    settle();
    tests++; if ({fpu_ack, wp_sel, wp_we, wp_wef, wp_wa} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      failed++; $display("FAIL x0_commit: got %0h expected %0h",
        {fpu_ack, wp_sel, wp_we, wp_wef, wp_wa}, {1'b1, 1'b1, 1'b0, 1'b0, 5'd0});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_wb_conflict();
    issue_op(5'd4, 1'b0, 1'b1);
    tick();
    clear_inputs();
    fpu_done = 1; wb_we = 1; wb_wa = 7;
    settle();
    tests++; if ({fpu_ack, wp_sel, wp_we, wp_wef, wp_wa} !== {1'b0, 1'b0, 1'b1, 1'b0, 5'd7}) begin
      failed++; $display("FAIL wbc_pipe_wins: got %0h expected %0h",
        {fpu_ack, wp_sel, wp_we, wp_wef, wp_wa}, {1'b0, 1'b0, 1'b1, 1'b0, 5'd7});
    end
    tick();
    wb_we = 0; wb_wa = 0;
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_wr = 1;
    settle();
    tests++; if ({stall, fpu_ack, wp_sel, wp_we, wp_wef, wp_wa} !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4}) begin
      failed++; $display("FAIL wbc_pend_commit: got %0h expected %0h",
        {stall, fpu_ack, wp_sel, wp_we, wp_wef, wp_wa}, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4});
    end
    tick();
    fpu_done = 0;
    settle();
    tests++; if ({stall, fpu_ack} !== 2'b00) begin
      failed++; $display("FAIL wbc_idle: got %0b expected 00", {stall, fpu_ack});
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    issue_op(5'd1, 1'b1, 1'b1);
    tick();
    id_valid = 1; id_fpu_op = 1; id_rs1 = 8; id_rs1_f = 1; id_rs2 = 9; id_rs2_f = 1;
    id_rd = 2; id_rd_f = 1; id_wr = 1;
    settle();
    tests++; if ({stall, fpu_start} !== 2'b10) begin
      failed++; $display("FAIL b2b_busy: got stall,start=%0b expected 10", {stall, fpu_start});
    end
    tick();
    fpu_done = 1;
    settle();
    tests++; if ({stall, fpu_start, fpu_ack, wp_wa} !== {1'b1, 1'b0, 1'b1, 5'd1}) begin
      failed++; $display("FAIL b2b_commit: got %0h expected %0h",
        {stall, fpu_start, fpu_ack, wp_wa}, {1'b1, 1'b0, 1'b1, 5'd1});
    end
    tick();
    fpu_done = 0;
    settle();
    tests++; if ({stall, fpu_start} !== 2'b01) begin
      failed++; $display("FAIL b2b_second_launch: got stall,start=%0b expected 01", {stall, fpu_start});
    end
    tick();
    clear_inputs(); fpu_done = 1;
    settle();
    tests++; if ({fpu_ack, wp_wef, wp_wa} !== {1'b1, 1'b1, 5'd2}) begin
      failed++; $display("FAIL b2b_second_commit: got %0h expected %0h",
        {fpu_ack, wp_wef, wp_wa}, {1'b1, 1'b1, 5'd2});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_idle_done_err();
    clear_inputs();
    settle();
    tests++; if (proto_err !== 1'b0) begin failed++; $display("FAIL err_clear_before: got %0b expected 0", proto_err); end
    fpu_done = 1;
    settle();
    tests++; if (fpu_ack !== 1'b0) begin failed++; $display("FAIL idle_done_ack: got %0b expected 0", fpu_ack); end
    tick();
    fpu_done = 0;
    tick();
    tick();
    tests++; if (proto_err !== 1'b1) begin failed++; $display("FAIL idle_done_sticky: got %0b expected 1", proto_err); end
    do_reset();
    tests++; if (proto_err !== 1'b0) begin failed++; $display("FAIL err_rst_clear: got %0b expected 0", proto_err); end
  endtask

  task automatic test_overflow();
    issue_op(5'd3, 1'b0, 1'b1);
    tick();
    clear_inputs();
    fpu_done = 1; wb_wef = 1; wb_wa = 11;
    tick();
    for (int i = 0; i < 6; i++) tick();
    tests++; if ({proto_err, fpu_ack, wp_sel} !== 3'b000) begin
      failed++; $display("FAIL ovf_6cyc: got err,ack,sel=%0b expected 000", {proto_err, fpu_ack, wp_sel});
    end
    tick();
    tests++; if ({proto_err, fpu_ack, wp_wef, wp_wa} !== {1'b1, 1'b0, 1'b1, 5'd11}) begin
      failed++; $display("FAIL ovf_7cyc: got %0h expected %0h",
        {proto_err, fpu_ack, wp_wef, wp_wa}, {1'b1, 1'b0, 1'b1, 5'd11});
    end
    tick();
    wb_wef = 0; wb_wa = 0;
    settle();
    tests++; if ({fpu_ack, wp_sel, wp_we, wp_wa} !== {1'b1, 1'b1, 1'b1, 5'd3}) begin
      failed++; $display("FAIL ovf_late_commit: got %0h expected %0h",
        {fpu_ack, wp_sel, wp_we, wp_wa}, {1'b1, 1'b1, 1'b1, 5'd3});
    end
    tick();
    clear_inputs();
    do_reset();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_raw();
    test_waw_and_file_mask();
    test_wb_conflict();
    test_back_to_back();
    test_idle_done_err();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
